// File: rtl/uart_link_pkg.sv
// uart_link_pkg: shared RX/TX state encodings and the default frame header byte.
package uart_link_pkg;
  localparam logic [7:0] DEF_HEADER = 8'hA5;
  typedef enum logic [1:0] {R_HDR, R_LEN, R_PAY, R_CHK} rx_state_t;
  typedef enum logic [2:0] {T_IDLE, T_HDR, T_LEN, T_PAY, T_CHK} tx_state_t;
endpackage

// File: rtl/uart_link.sv
// uart_link: framed link (HEADER, LEN, payload, XOR checksum) between a user stream and UART FIFOs.
// Ports: CLK/RST (async, active-high); u_* talk to the UART receive/send FIFOs;
// rx_valid/rx_data/rx_done/rx_ok deliver received frames; tx_start/tx_len/tx_valid/tx_data/tx_ready/tx_busy send frames.
module uart_link
  import uart_link_pkg::*;
#(
  parameter logic [7:0]  HEADER         = DEF_HEADER,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       u_receivable,
  input  logic [7:0] u_recv_data,
  output logic       u_recv_flag,
  input  logic       u_sendable,
  output logic [7:0] u_send_data,
  output logic       u_send_flag,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_ok,
  input  logic       tx_start,
  input  logic [7:0] tx_len,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  rx_state_t rx_st, rx_st_n;
  tx_state_t tx_st, tx_st_n;
  logic [7:0] rx_cnt, rx_cnt_n, rx_chk, rx_chk_n, rx_data_n;
  logic [7:0] tx_cnt, tx_cnt_n, tx_chk, tx_chk_n;
  logic [TW-1:0] tmo, tmo_n;
  logic rx_valid_n, rx_done_n, rx_ok_n, tx_push;
  // The FIFO head is consumed whenever present; the RX path never stalls.
  assign u_recv_flag = u_receivable & ~RST;
  assign tx_busy = tx_st != T_IDLE;
  always_comb begin
    rx_st_n = rx_st;
    rx_cnt_n = rx_cnt;
    rx_chk_n = rx_chk;
    tmo_n = tmo;
    rx_valid_n = 1'b0;
    rx_data_n = rx_data;
    rx_done_n = 1'b0;
    rx_ok_n = 1'b0;
    if (u_recv_flag) begin
      tmo_n = '0;
      case (rx_st)
        R_HDR: rx_st_n = (u_recv_data == HEADER) ? R_LEN : R_HDR;
        R_LEN: begin
          rx_done_n = u_recv_data == 8'd0;
          rx_cnt_n = u_recv_data;
          rx_chk_n = u_recv_data;
          rx_st_n = (u_recv_data == 8'd0) ? R_HDR : R_PAY;
        end
        R_PAY: begin
          rx_valid_n = 1'b1;
          rx_data_n = u_recv_data;
          rx_chk_n = rx_chk ^ u_recv_data;
          rx_cnt_n = rx_cnt - 8'd1;
          rx_st_n = (rx_cnt == 8'd1) ? R_CHK : R_PAY;
        end
        R_CHK: begin
          rx_done_n = 1'b1;
          rx_ok_n = u_recv_data == rx_chk;
          rx_st_n = R_HDR;
        end
      endcase
    end else if (rx_st != R_HDR) begin
      // Idle gap inside a frame: abandon it as failed once the budget runs out.
      rx_done_n = tmo == TMO_MAX;
      rx_st_n = (tmo == TMO_MAX) ? R_HDR : rx_st;
      tmo_n = (tmo == TMO_MAX) ? '0 : tmo + 1'b1;
    end
  end
  always_comb begin
    tx_st_n = tx_st;
    tx_cnt_n = tx_cnt;
    tx_chk_n = tx_chk;
    tx_ready = tx_st == T_PAY && u_sendable;
    tx_push = 1'b0;
    u_send_data = 8'd0;
    case (tx_st)
      T_IDLE: if (tx_start && tx_len != 8'd0) begin
        tx_cnt_n = tx_len;
        tx_chk_n = tx_len;
        tx_st_n = T_HDR;
      end
      T_HDR: begin
        u_send_data = HEADER;
        tx_push = u_sendable;
        tx_st_n = u_sendable ? T_LEN : T_HDR;
      end
      T_LEN: begin
        // The count is untouched until payload starts, so it still holds LEN.
        u_send_data = tx_cnt;
        tx_push = u_sendable;
        tx_st_n = u_sendable ? T_PAY : T_LEN;
      end
      T_PAY: begin
        u_send_data = tx_data;
        tx_push = u_sendable && tx_valid;
        if (u_sendable && tx_valid) begin
          tx_chk_n = tx_chk ^ tx_data;
          tx_cnt_n = tx_cnt - 8'd1;
          tx_st_n = (tx_cnt == 8'd1) ? T_CHK : T_PAY;
        end
      end
      T_CHK: begin
        u_send_data = tx_chk;
        tx_push = u_sendable;
        tx_st_n = u_sendable ? T_IDLE : T_CHK;
      end
      default: tx_st_n = T_IDLE;
    endcase
    u_send_flag = tx_push;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      rx_st <= R_HDR;
      rx_cnt <= '0;
      rx_chk <= '0;
      tmo <= '0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_done <= 1'b0;
      rx_ok <= 1'b0;
      tx_st <= T_IDLE;
      tx_cnt <= '0;
      tx_chk <= '0;
    end else begin
      rx_st <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_chk <= rx_chk_n;
      tmo <= tmo_n;
      rx_valid <= rx_valid_n;
      rx_data <= rx_data_n;
      rx_done <= rx_done_n;
      rx_ok <= rx_ok_n;
      tx_st <= tx_st_n;
      tx_cnt <= tx_cnt_n;
      tx_chk <= tx_chk_n;
    end
endmodule
